// File: rtl/startup_gen_if.sv
// Signal bundle between the startup generator and its user:
// enable/feedback in, drive/lock status and current half-period out.
interface startup_gen_if #(
    parameter int unsigned HP_W = 10
);
    logic            en;
    logic            fb;
    logic            gen;
    logic            locked;
    logic [HP_W-1:0] half_per;

    modport master (output en, output fb, input gen, input locked, input half_per);
    modport slave  (input en, input fb, output gen, output locked, output half_per);
endinterface

// File: rtl/startup_gen.sv
// Startup square-wave oscillator feeding the primary-feedback selector's gen input.
// Define STARTUP_TRACK_EN to build feedback half-period tracking; otherwise half_per is fixed.
module startup_gen #(
    parameter int unsigned CLK_MHZ       = 100,
    parameter int unsigned F_START_KHZ   = 200,
    parameter int unsigned F_MIN_KHZ     = 50,
    parameter int unsigned F_MAX_KHZ     = 500,
    parameter int unsigned FB_TIMEOUT_US = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    startup_gen_if.slave bus
);
    localparam int unsigned HP_START = CLK_MHZ * 1000 / (2 * F_START_KHZ);
    localparam int unsigned HP_MAX   = CLK_MHZ * 1000 / (2 * F_MIN_KHZ);
    localparam int unsigned HP_MIN   = CLK_MHZ * 1000 / (2 * F_MAX_KHZ);
    localparam int unsigned TO_CNT   = CLK_MHZ * FB_TIMEOUT_US;
    localparam int unsigned HP_W     = $clog2(HP_MAX + 1);
    localparam int unsigned TO_W     = $clog2(TO_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            gen_q, gen_d, gen_tick_c;
    logic [HP_W-1:0] cnt_q, cnt_d, cnt_tick_c;
    logic [HP_W-1:0] half_per;
    logic            locked;
    logic            en_s1, en_s2, en_d;
    logic            en_rise_c, en_fall_c;

    // Enable chain resets high so an enable already asserted at reset release needs a fresh rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1 <= 1'b1;
            en_s2 <= 1'b1;
            en_d  <= 1'b1;
        end else begin
            en_s1 <= bus.en;
            en_s2 <= en_s1;
            en_d  <= en_s2;
        end
    end

    assign en_rise_c = en_s2 & ~en_d;
    assign en_fall_c = ~en_s2 & en_d;

    // One half-counter step: toggle and reload from the live half_per at terminal count.
    always_comb begin
        gen_tick_c = gen_q;
        cnt_tick_c = cnt_q - HP_W'(1);
        if (cnt_q == '0) begin
            gen_tick_c = ~gen_q;
            cnt_tick_c = half_per - HP_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gen_d = 1'b0;
                if (en_rise_c) begin
                    state_d = RUN;
                    gen_d   = 1'b1;
                    cnt_d   = half_per - HP_W'(1);
                end
            end
            RUN: begin
                if (en_fall_c && (!gen_q || cnt_q == '0)) begin
                    state_d = IDLE;
                    gen_d   = 1'b0;
                end else begin
                    gen_d = gen_tick_c;
                    cnt_d = cnt_tick_c;
                    if (en_fall_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish the high half so no runt pulse reaches the bridge.
                if (en_rise_c) begin
                    state_d = RUN;
                    gen_d   = gen_tick_c;
                    cnt_d   = cnt_tick_c;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    gen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_tick_c;
                end
            end
            default: begin
                state_d = IDLE;
                gen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gen_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STARTUP_TRACK_EN
    logic            fb_s1, fb_s2, fb_d, fb_edge_c;
    logic [HP_W-1:0] meas_cnt, m_q, m_prev;
    logic            m_vld;
    logic [TO_W-1:0] to_cnt;
    logic [HP_W:0]   diff_c;
    logic            accept_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_s1 <= 1'b0;
            fb_s2 <= 1'b0;
            fb_d  <= 1'b0;
        end else begin
            fb_s1 <= bus.fb;
            fb_s2 <= fb_s1;
            fb_d  <= fb_s2;
        end
    end

    assign fb_edge_c = fb_s2 ^ fb_d;

    // Edge-to-edge interval; HP_MAX+1 marks an out-of-range (lost) period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_cnt <= '0;
            m_q      <= '0;
            m_vld    <= 1'b0;
            to_cnt   <= TO_W'(TO_CNT);
        end else begin
            m_vld <= fb_edge_c;
            if (fb_edge_c) begin
                meas_cnt <= HP_W'(1);
                m_q      <= meas_cnt;
                to_cnt   <= TO_W'(TO_CNT);
            end else begin
                if (meas_cnt != HP_W'(HP_MAX + 1)) begin
                    meas_cnt <= meas_cnt + HP_W'(1);
                end
                if (to_cnt != '0) begin
                    to_cnt <= to_cnt - TO_W'(1);
                end
            end
        end
    end

    assign diff_c   = (m_q > m_prev) ? ({1'b0, m_q} - {1'b0, m_prev})
                                     : ({1'b0, m_prev} - {1'b0, m_q});
    assign accept_c = (m_q >= HP_W'(HP_MIN)) && (m_q <= HP_W'(HP_MAX))
                   && (diff_c <= (HP_W+1)'(m_prev >> 3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_per <= HP_W'(HP_START);
            locked   <= 1'b0;
            m_prev   <= '0;
        end else if (m_vld) begin
            m_prev <= m_q;
            if (accept_c) begin
                half_per <= m_q;
                locked   <= 1'b1;
            end
        end else if (to_cnt == '0) begin
            locked <= 1'b0;
            m_prev <= '0;
        end
    end
`else
    assign half_per = HP_W'(HP_START);
    assign locked   = 1'b0;
`endif

    assign bus.gen      = gen_q;
    assign bus.locked   = locked;
    assign bus.half_per = half_per;
endmodule

// File: tb/tb_startup_gen.sv
// Directed/randomised bench for startup_gen against a timestamp-based reference model.
module tb_startup_gen;
    localparam int unsigned HP_START = 250;
    localparam int unsigned HP_MIN   = 100;
    localparam int unsigned HP_MAX   = 1000;
    localparam int unsigned TO_CNT   = 400;
    localparam int unsigned HP_W     = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    int unsigned m_hp = HP_START;
    bit          m_locked = 1'b0;
    int unsigned m_prev = 0;
    int unsigned last_edge = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    startup_gen_if #(.HP_W(HP_W)) bus ();

    startup_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected gen after posedge pc: burst started at s, en fall acted at f.
    function automatic int unsigned gen_model(input int unsigned pc, input int unsigned s,
                                              input int unsigned hp, input int unsigned f,
                                              input bit fell);
        int unsigned k;
        if (pc < s) return 0;
        if (!fell || pc < f) return (((pc - s) / hp) % 2 == 0) ? 1 : 0;
        k = (f - 1 - s) / hp;
        if (k % 2 == 1) return 0;
        return (pc < s + (k + 1) * hp) ? 1 : 0;
    endfunction

    // Apply one feedback edge that follows the previous one by gap clocks.
    task automatic model_edge(input int unsigned gap);
        int unsigned m, diff;
        bit accept;
        if (gap > TO_CNT) begin
            m_prev = 0;
`ifdef STARTUP_TRACK_EN
            m_locked = 1'b0;
`endif
        end
        m      = (gap > HP_MAX) ? HP_MAX + 1 : gap;
        diff   = (m > m_prev) ? m - m_prev : m_prev - m;
        accept = (m >= HP_MIN) && (m <= HP_MAX) && (diff <= (m_prev >> 3));
        if (accept) begin
`ifdef STARTUP_TRACK_EN
            m_hp     = m;
            m_locked = 1'b1;
`endif
        end
        m_prev = m;
    endtask

    task automatic run_burst(input int unsigned d, input string tag);
        int unsigned s, f, hp;
        bit fell;
        hp   = m_hp;
        s    = cyc + 3;
        f    = 0;
        fell = 1'b0;
        bus.en = 1'b1;
        for (int i = 1; i <= int'(d); i++) begin
            tick();
            check({tag, "_gen"}, 32'(bus.gen), gen_model(cyc, s, hp, f, fell));
        end
        bus.en = 1'b0;
        f      = cyc + 3;
        fell   = 1'b1;
        while (cyc < f + hp + 10) begin
            tick();
            check({tag, "_gen_tail"}, 32'(bus.gen), gen_model(cyc, s, hp, f, fell));
        end
        check({tag, "_locked"}, 32'(bus.locked), 32'(m_locked));
        check({tag, "_half_per"}, 32'(bus.half_per), m_hp);
    endtask

    task automatic fb_step(input int unsigned hold);
        int unsigned hp_old;
        hp_old = m_hp;
        bus.fb = ~bus.fb;
        model_edge(cyc - last_edge);
        last_edge = cyc;
        for (int i = 1; i <= int'(hold); i++) begin
            tick();
            if (i == 3) check("fb_update_not_early", 32'(bus.half_per), hp_old);
            if (i == 4) begin
                check("fb_half_per", 32'(bus.half_per), m_hp);
                check("fb_locked", 32'(bus.locked), 32'(m_locked));
            end
        end
    endtask

    task automatic fb_stop();
        while (cyc < last_edge + TO_CNT + 10) tick();
        m_locked = 1'b0;
        check("timeout_locked", 32'(bus.locked), 32'(m_locked));
        check("timeout_half_per", 32'(bus.half_per), m_hp);
    endtask

    initial begin
        int unsigned s;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.fb = 1'b0;
        repeat (3) tick();
        check("reset_gen", 32'(bus.gen), 0);
        check("reset_locked", 32'(bus.locked), 0);
        check("reset_half_per", 32'(bus.half_per), HP_START);
        rst_n     = 1'b1;
        last_edge = cyc;
        repeat (5) tick();
        check("idle_gen", 32'(bus.gen), 0);

        run_burst(1000, "burst_10us");
        run_burst(3 + 2 * m_hp + 100, "fall_in_high");
        run_burst(3 + m_hp + 50, "fall_in_low");
        run_burst($urandom_range(5, 1500), "burst_rand0");

        // Feedback square at 300 clocks per half
        while (cyc < last_edge + 1200) tick();
        repeat (6) fb_step(300);
        fb_stop();
        run_burst($urandom_range(5, 1500), "burst_tracked");

        // Jumps, out-of-range and lost halves
        fb_step(300); fb_step(300); fb_step(300); fb_step(400);
        fb_step(300); fb_step(50);  fb_step(300); fb_step(300);
        fb_step(1200); fb_step(300); fb_step(300); fb_step(300);
        fb_stop();

        // Jittered feedback around the startup frequency
        repeat (16) fb_step(220 + $urandom_range(0, 60));
        fb_stop();
        run_burst($urandom_range(5, 1500), "burst_rand1");

        // Asynchronous reset in the middle of a burst
        bus.en = 1'b1;
        s = cyc + 3;
        repeat (10) tick();
        check("pre_reset_gen", 32'(bus.gen), gen_model(cyc, s, m_hp, 0, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_gen", 32'(bus.gen), 0);
        check("async_reset_half_per", 32'(bus.half_per), HP_START);
        check("async_reset_locked", 32'(bus.locked), 0);
        m_hp     = HP_START;
        m_locked = 1'b0;
        m_prev   = 0;
        tick();
        rst_n     = 1'b1;
        last_edge = cyc;
        repeat (20) begin
            tick();
            check("no_restart_gen", 32'(bus.gen), 0);
        end
        bus.en = 1'b0;
        repeat (5) tick();
        run_burst($urandom_range(600, 1200), "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
